// File: rtl/proc_pkg.sv
// Shared decode constants for the operand-fetch stage: opcodes, instruction
// field positions and default widths.
package proc_pkg;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 4;

  localparam logic [3:0] OP_STORE = 4'hC;
  localparam logic [3:0] OP_BR    = 4'hD;
  localparam logic [3:0] OP_NOP   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int DST_MSB  = 11;
  localparam int DST_LSB  = 8;
  localparam int SRC1_MSB = 7;
  localparam int SRC1_LSB = 4;
  localparam int SRC2_MSB = 3;
  localparam int SRC2_LSB = 0;

  // Everything below the store opcode produces a register result.
  function automatic logic op_writes(input logic [3:0] op);
    return (op < OP_STORE);
  endfunction
endpackage

// File: rtl/operand_fetch_if.sv
// Bus bundle between the operand-fetch stage and its neighbours: instruction
// input, regfile read port, writeback and the operand bundle to execute.
interface operand_fetch_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_instr;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_op;
  logic [AW-1:0] out_dst;
  logic          out_wr;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;

  modport slave (
    input  in_valid, in_instr, rd1, rd2, wb_valid, wb_addr, wb_data, out_ready,
    output in_ready, ra1, ra2, out_valid, out_op, out_dst, out_wr, out_a, out_b
  );

  modport master (
    output in_valid, in_instr, rd1, rd2, wb_valid, wb_addr, wb_data, out_ready,
    input  in_ready, ra1, ra2, out_valid, out_op, out_dst, out_wr, out_a, out_b
  );
endinterface

// File: rtl/op_scoreboard.sv
// Per-register pending-write tracker and RAW/WAW hazard check; a writeback in
// the current cycle counts as resolving the hazard for its register.
module op_scoreboard #(
  parameter int AW   = 4,
  parameter int NREG = 2**AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            issue,
  input  logic            wr,
  input  logic [AW-1:0]   dst,
  input  logic [AW-1:0]   src1,
  input  logic [AW-1:0]   src2,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  output logic [NREG-1:0] busy,
  output logic            hazard
);
  logic [NREG-1:0] busy_d, busy_q;
  logic byp1, byp2, byp_dst;

  assign byp1    = wb_valid && (wb_addr == src1);
  assign byp2    = wb_valid && (wb_addr == src2);
  assign byp_dst = wb_valid && (wb_addr == dst);

  assign hazard = (busy_q[src1] && !byp1) ||
                  (busy_q[src2] && !byp2) ||
                  (wr && busy_q[dst] && !byp_dst);

  // Set is applied after clear so a same-cycle issue to the written register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid)
      busy_d[wb_addr] = 1'b0;
    if (issue && wr)
      busy_d[dst] = 1'b1;
    if (flush)
      busy_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;
endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: decodes register fields, reads the regfile with
// writeback bypass, stalls on scoreboard hazards and registers the operand bundle.
module operand_fetch
  import proc_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int NREG = 2**AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  operand_fetch_if.slave  io,
  output logic [NREG-1:0] busy
);
  logic [3:0]    op;
  logic [AW-1:0] dst, src1, src2;
  logic          wr, hazard, space, issue;
  logic [DW-1:0] a_val, b_val;

  logic          out_valid_d, out_valid_q;
  logic [3:0]    out_op_d, out_op_q;
  logic [AW-1:0] out_dst_d, out_dst_q;
  logic          out_wr_d, out_wr_q;
  logic [DW-1:0] out_a_d, out_a_q;
  logic [DW-1:0] out_b_d, out_b_q;

  assign op   = io.in_instr[OP_MSB:OP_LSB];
  assign dst  = io.in_instr[DST_MSB:DST_LSB];
  assign src1 = io.in_instr[SRC1_MSB:SRC1_LSB];
  assign src2 = io.in_instr[SRC2_MSB:SRC2_LSB];
  assign wr   = op_writes(op);

  assign io.ra1 = src1;
  assign io.ra2 = src2;

  // The regfile writes on the same edge, so its read port still shows the old value.
  assign a_val = (io.wb_valid && io.wb_addr == src1) ? io.wb_data : io.rd1;
  assign b_val = (io.wb_valid && io.wb_addr == src2) ? io.wb_data : io.rd2;

  assign space       = !out_valid_q || io.out_ready;
  assign io.in_ready = space && !hazard && !flush && !rst;
  assign issue       = io.in_valid && io.in_ready;

  op_scoreboard #(.AW(AW), .NREG(NREG)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .issue    (issue),
    .wr       (wr),
    .dst      (dst),
    .src1     (src1),
    .src2     (src2),
    .wb_valid (io.wb_valid),
    .wb_addr  (io.wb_addr),
    .busy     (busy),
    .hazard   (hazard)
  );

  // Payload only moves on issue; a consumed bundle just drops valid.
  always_comb begin
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_dst_d   = out_dst_q;
    out_wr_d    = out_wr_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    if (issue) begin
      out_valid_d = 1'b1;
      out_op_d    = op;
      out_dst_d   = dst;
      out_wr_d    = wr;
      out_a_d     = a_val;
      out_b_d     = b_val;
    end else if (out_valid_q && io.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (flush)
      out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_dst_q   <= '0;
      out_wr_q    <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_dst_q   <= out_dst_d;
      out_wr_q    <= out_wr_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_op    = out_op_q;
  assign io.out_dst   = out_dst_q;
  assign io.out_wr    = out_wr_q;
  assign io.out_a     = out_a_q;
  assign io.out_b     = out_b_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: regfile model, expected-bundle queue popped
// on each output handshake, plus direct checks of ready/busy/reset state.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [15:0] busy;

  operand_fetch_if #(.DW(16), .AW(4)) bus ();

  operand_fetch dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .io    (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  logic [15:0] rf [16];
  assign bus.rd1 = rf[bus.ra1];
  assign bus.rd2 = rf[bus.ra2];

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  dst;
    logic        wr;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [3:0] dst, input logic wr,
                      input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.op = op; e.dst = dst; e.wr = wr; e.a = a; e.b = b;
    q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [15:0] instr);
    bus.in_valid = v;
    bus.in_instr = instr;
    #1;
  endtask

  // Pops/compares on a handshake, advances one clock, updates the regfile model.
  task automatic tick();
    exp_t e;
    if (bus.out_valid && bus.out_ready) begin
      nchk++;
      assert (q.size() != 0) else begin
        errs++;
        $error("FAIL bundle_unexpected: got op=%h dst=%h with empty queue", bus.out_op, bus.out_dst);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("bundle_op",  {28'd0, bus.out_op},  {28'd0, e.op});
        chk("bundle_dst", {28'd0, bus.out_dst}, {28'd0, e.dst});
        chk("bundle_wr",  {31'd0, bus.out_wr},  {31'd0, e.wr});
        chk("bundle_a",   {16'd0, bus.out_a},   {16'd0, e.a});
        chk("bundle_b",   {16'd0, bus.out_b},   {16'd0, e.b});
      end
    end
    @(posedge clk);
    if (bus.wb_valid) rf[bus.wb_addr] = bus.wb_data;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'h1000 + 16'(i);
    rf[2] = 16'hAAAA;
    rf[3] = 16'hBBBB;
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0;
    bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);

    // Reset state
    drive(1'b1, 16'h0123);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("ra1", {28'd0, bus.ra1}, 32'd2);
    chk("ra2", {28'd0, bus.ra2}, 32'd3);
    tick();
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_op", {28'd0, bus.out_op}, 32'd0);
    chk("rst_out_a", {16'd0, bus.out_a}, 32'd0);
    chk("rst_out_b", {16'd0, bus.out_b}, 32'd0);
    chk("rst_out_wr", {31'd0, bus.out_wr}, 32'd0);
    chk("rst_busy", {16'd0, busy}, 32'd0);

    // First issue
    rst = 1'b0;
    drive(1'b1, 16'h0123);
    chk("issue0_ready", {31'd0, bus.in_ready}, 32'd1);
    push(4'h0, 4'h1, 1'b1, 16'hAAAA, 16'hBBBB);
    tick();
    chk("issue0_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("issue0_busy", {16'd0, busy}, 32'h0002);

    // RAW stall on r1, then resolved by a bypassed writeback
    drive(1'b1, 16'h2415);
    chk("raw_stall_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    chk("raw_drained_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("raw_busy_held", {16'd0, busy}, 32'h0002);
    bus.wb_valid = 1'b1; bus.wb_addr = 4'd1; bus.wb_data = 16'hCCCC;
    drive(1'b1, 16'h2415);
    chk("raw_bypass_ready", {31'd0, bus.in_ready}, 32'd1);
    push(4'h2, 4'h4, 1'b1, 16'hCCCC, 16'h1005);
    tick();
    bus.wb_valid = 1'b0;
    chk("raw_busy_after", {16'd0, busy}, 32'h0010);

    // Backpressure: bundle holds, input blocked
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h3067);
    chk("bp_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_op", {28'd0, bus.out_op}, 32'h2);
    chk("bp_dst", {28'd0, bus.out_dst}, 32'h4);
    chk("bp_a", {16'd0, bus.out_a}, 32'hCCCC);
    chk("bp_b", {16'd0, bus.out_b}, 32'h1005);
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h3067);
    chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    push(4'h3, 4'h0, 1'b1, 16'h1006, 16'h1007);
    tick();
    chk("bp_release_busy", {16'd0, busy}, 32'h0011);

    // Store: no write, dst busy is not a hazard
    drive(1'b1, 16'hC012);
    chk("store_ready", {31'd0, bus.in_ready}, 32'd1);
    push(4'hC, 4'h0, 1'b0, 16'hCCCC, 16'hAAAA);
    tick();
    chk("store_busy", {16'd0, busy}, 32'h0011);

    // Retire r0, then mark r1..r15 busy
    bus.wb_valid = 1'b1; bus.wb_addr = 4'd0; bus.wb_data = 16'h0000;
    drive(1'b0, 16'h0000);
    tick();
    bus.wb_valid = 1'b0;
    chk("r0_clear_busy", {16'd0, busy}, 32'h0010);
    for (int k = 1; k < 16; k++) begin
      if (k == 4) continue;
      drive(1'b1, {4'h1, 4'(k), 8'h00});
      chk("fill_ready", {31'd0, bus.in_ready}, 32'd1);
      push(4'h1, 4'(k), 1'b1, 16'h0000, 16'h0000);
      tick();
    end
    chk("fill_busy", {16'd0, busy}, 32'hFFFE);
    drive(1'b1, 16'h1055);
    chk("busy_src_stall", {31'd0, bus.in_ready}, 32'd0);
    tick();
    drive(1'b1, 16'hE000);
    chk("nop_ready", {31'd0, bus.in_ready}, 32'd1);
    push(4'hE, 4'h0, 1'b0, 16'h0000, 16'h0000);
    tick();
    chk("nop_busy", {16'd0, busy}, 32'hFFFE);

    // Same-cycle clear and set of r5: set wins
    bus.wb_valid = 1'b1; bus.wb_addr = 4'd5; bus.wb_data = 16'h5555;
    drive(1'b1, 16'h1500);
    chk("setclr_ready", {31'd0, bus.in_ready}, 32'd1);
    push(4'h1, 4'h5, 1'b1, 16'h0000, 16'h0000);
    tick();
    bus.wb_valid = 1'b0;
    chk("setclr_busy", {16'd0, busy}, 32'hFFFE);

    // Flush drops the pending bundle and clears the scoreboard
    bus.out_ready = 1'b0;
    flush = 1'b1;
    drive(1'b1, 16'h1000);
    chk("flush1_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    q.delete();
    chk("flush1_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush1_busy", {16'd0, busy}, 32'd0);
    bus.out_ready = 1'b1;
    for (int k = 4; k < 8; k++) begin
      drive(1'b1, {4'h1, 4'(k), 8'h00});
      push(4'h1, 4'(k), 1'b1, 16'h0000, 16'h0000);
      tick();
    end
    chk("pre_flush_busy", {16'd0, busy}, 32'h00F0);
    chk("pre_flush_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b0;
    flush = 1'b1;
    drive(1'b1, 16'h1800);
    chk("flush2_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    q.delete();
    chk("flush2_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush2_busy", {16'd0, busy}, 32'd0);

    // Reset while stalled behind a pending bundle
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h1100);
    push(4'h1, 4'h1, 1'b1, 16'h0000, 16'h0000);
    tick();
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h1210);
    chk("stall_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    rst = 1'b1;
    drive(1'b1, 16'h1210);
    tick();
    q.delete();
    chk("rst2_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst2_op", {28'd0, bus.out_op}, 32'd0);
    chk("rst2_dst", {28'd0, bus.out_dst}, 32'd0);
    chk("rst2_wr", {31'd0, bus.out_wr}, 32'd0);
    chk("rst2_a", {16'd0, bus.out_a}, 32'd0);
    chk("rst2_busy", {16'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode/operand-fetch stage sitting directly upstream of the 16x16 register file.
- Accepts 16-bit instructions over a valid/ready handshake and decodes their register fields.
- Drives the regfile read addresses, applies writeback bypass to the read data, and presents a registered operand bundle to the execute stage over valid/ready.
- Holds a per-register busy scoreboard and stalls issue on RAW/WAW hazards until the corresponding writeback arrives.

Parameters:
- DW, 16, data width of registers and operands.
- AW, 4, register address width.
- NREG, 16, number of architectural registers (2**AW).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard the output register and clear the scoreboard.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  16  [15:12] op, [11:8] dst, [7:4] src1, [3:0] src2.
- ra1  out  AW  regfile read address 1; equals in_instr[7:4], combinational.
- ra2  out  AW  regfile read address 2; equals in_instr[3:0], combinational.
- rd1  in  DW  regfile read data 1 (combinational read).
- rd2  in  DW  regfile read data 2.
- wb_valid  in  1  writeback this cycle; the regfile writes on the same edge.
- wb_addr  in  AW  writeback register.
- wb_data  in  DW  writeback value.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  execute stage accepts the bundle.
- out_op  out  4  opcode.
- out_dst  out  AW  destination register.
- out_wr  out  1  instruction writes out_dst.
- out_a  out  DW  operand for src1.
- out_b  out  DW  operand for src2.
- busy  out  NREG  scoreboard; bit i set means register i has a pending write.

Behaviour:
- Reset: synchronous on rst=1.
  - out_valid=0; out_op, out_dst, out_a, out_b = 0; out_wr=0; busy=0.
  - in_ready=0 while rst=1.
- Decode:
  - wr = (op <= 4'hB).
  - Ops C (store), D (branch), E (nop) and F (halt) do not write dst.
- Bypass:
  - a_val = (wb_valid && wb_addr==src1) ? wb_data : rd1. b_val is formed the same way from src2/rd2.
  - A bypassed source counts as not busy.
- Hazard:
  - Raised if (busy[src1] && !byp1) or (busy[src2] && !byp2) or (wr && busy[dst] && !(wb_valid && wb_addr==dst)).
- Handshake:
  - space = !out_valid || out_ready.
  - in_ready = space && !hazard && !flush && !rst. This is combinational from in_instr, busy and wb_*.
  - Issue = in_valid && in_ready.
  - On issue, the output register loads op, dst, wr, a_val and b_val, and out_valid<=1. Latency is 1 cycle from accept to out_valid.
  - If the output is consumed (out_valid && out_ready) with no issue: out_valid<=0 and the data is held.
  - If out_valid && !out_ready: all outputs hold stable.
- Scoreboard, per edge:
  - wb_valid clears busy[wb_addr].
  - An issue with wr=1 sets busy[dst].
  - When the set and the clear target the same register in the same cycle, set wins.
- Flush:
  - Next edge: out_valid<=0 and busy<=0.
  - No issue occurs in a flush cycle.
  - rst has priority over flush.
- Edge cases:
  - Instructions whose src1==src2 are handled normally.
  - Writebacks to non-busy registers are legal; clearing a non-busy bit is a no-op.
  - Reset mid-stall drops the pending bundle.

Decomposition:
- Shared package proc_pkg holds:
  - opcode localparams OP_STORE=4'hC, OP_BR=4'hD, OP_NOP=4'hE, OP_HALT=4'hF;
  - instruction field bit positions;
  - DW/AW defaults.
- One natural sub-module, op_scoreboard, containing the busy vector, set/clear logic and the hazard check.
- Decode, bypass and the output register stay in operand_fetch.

Test Plan:
- Reset then issue 16'h0123 with regfile r2=AAAA, r3=BBBB:
  - in_ready=1;
  - the next cycle shows out_valid=1, op=0, dst=1, wr=1, a=AAAA, b=BBBB;
  - busy=16'h0002.
- RAW stall: with busy[1] set, present 16'h2415:
  - in_ready=0 while busy;
  - a writeback of r1=CCCC is bypassed in the same cycle, so the bundle carries a=CCCC and busy[1] clears, then busy[4] sets.
- Backpressure: hold out_ready=0 with out_valid=1:
  - out_* stay stable and in_ready=0;
  - raising out_ready accepts the next instruction in the same cycle.
- Non-writing op 16'hC012:
  - out_wr=0 and busy is unchanged;
  - 16'hE000 (nop) issues while every register is busy except r0.
- Simultaneous set/clear: wb_addr=5 in the same cycle as issuing dst=5 leaves busy[5]=1.
- flush=1 with out_valid=1 and busy=16'h00F0:
  - the next cycle has out_valid=0 and busy=0;
  - rst=1 mid-stall gives all outputs 0 on the next edge.
